blink_tick_gen: RTL and testbench
=================================

# blink_tick_gen

Upstream stage of the LED blinker. It debounces the raw push button, steps through four blink-rate settings on each press, and emits a one-cycle `tick` enable at the selected period. The downstream LED toggler flips its LEDs on each `tick` and needs no counter of its own. The block runs entirely in the `CLOCK_50` domain.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable samples required to accept a press or release (5 ms at 50 MHz).
- `PERIOD0`, default 5000: tick period in cycles for rate 0.
- `PERIOD1`, default 500000: tick period for rate 1.
- `PERIOD2`, default 5000000: tick period for rate 2.
- `PERIOD3`, default 25000000: tick period for rate 3.
- `CNT_W`, default 33: period counter width.
- Constraint: every `PERIODn` ≥ 2 and < 2^`CNT_W`. `DEBOUNCE_CYCLES` ≥ 2.

Ports:
- `CLOCK_50`, input, 1: system clock.
- `reset`, input, 1: one clock; reset is asynchronous and active-high.
- `KEY`, input, 1: raw push button, active-low (0 = pressed), asynchronous to `CLOCK_50`.
- `run_en`, input, 1: 1 = period counter runs; 0 = counter frozen.
- `tick`, output, 1: one-cycle pulse, registered.
- `rate_sel`, output, 2: current rate index, registered.
- `key_pulse`, output, 1: one-cycle pulse per accepted press, registered.

## Operation
- **Synchronizer.** `KEY` passes through two flops, s1 then s2. Both reset to 1 (released).
- **Debounce FSM.** States UP, DOWN_PEND, DOWN, UP_PEND. Reset state is UP with the debounce counter at 0.
  - UP: if s2 = 0, go to DOWN_PEND and clear the counter.
  - DOWN_PEND: if s2 = 1, return to UP. Otherwise increment the counter. When the counter = `DEBOUNCE_CYCLES`-1, go to DOWN and set `key_pulse` to 1 for one cycle.
  - DOWN: if s2 = 1, go to UP_PEND and clear the counter.
  - UP_PEND: if s2 = 0, return to DOWN. Otherwise count. At `DEBOUNCE_CYCLES`-1, go to UP. No pulse is generated on release.
- **Rate selection.** On an edge where `key_pulse` = 1: `rate_sel` ← `rate_sel`+1 (mod 4, so 3 wraps to 0) and the period counter `cnt` ← 0.
- **Period counter.** Evaluated with this priority, on every edge:
  1. If `key_pulse` = 1: `cnt` ← 0 and `tick` ← 0.
  2. Else if `run_en` = 0: `cnt` holds and `tick` ← 0.
  3. Else if `cnt` = `PERIOD[rate_sel]`-1: `cnt` ← 0 and `tick` ← 1.
  4. Else: `cnt` ← `cnt`+1 and `tick` ← 0.
- **Period arithmetic.** The compare uses `CNT_W`-bit unsigned arithmetic. The period is selected combinationally from `rate_sel`.
- **Reset values.** `tick` = 0, `key_pulse` = 0, `rate_sel` = 0, `cnt` = 0, FSM = UP, s1 = s2 = 1.

## Timing
- **Press latency.** Let `KEY` first be sampled low at edge 1:
  - s2 = 0 after edge 2.
  - DOWN_PEND is entered at edge 3.
  - `key_pulse` = 1 after edge 3+`DEBOUNCE_CYCLES`-1, for exactly one cycle.
  - `rate_sel` updates on the following edge.
- **Glitch rejection.** A bounce (s2 returns to 1) during DOWN_PEND returns the FSM to UP with no pulse. A later press restarts debounce from 0.
- **Holding the key.** A held key produces one pulse only. Another pulse requires a full debounced release followed by a new press.
- **Tick spacing.** With `run_en` held at 1 and no presses, `tick` is high for one cycle every `PERIOD[rate_sel]` cycles. The first tick after reset release, or after a rate change, appears after the `PERIOD`-th edge.
- **run_en low.** `cnt` is frozen and no tick is produced. Counting resumes from the frozen value when `run_en` returns to 1.
- **Simultaneous events.** If `key_pulse` coincides with the terminal count, `key_pulse` wins: no tick, and the counter restarts under the new rate.
- **Reset mid-operation.** Everything returns to reset values immediately; any pending debounce is discarded. If the key is held through reset release, the FSM debounces it from UP and produces one pulse.

## Structure
- **Package `blink_pkg`** holds:
  - the FSM state encoding: UP = 2'd0, DOWN_PEND = 2'd1, DOWN = 2'd2, UP_PEND = 2'd3;
  - the rate index width (2);
  - the default `PERIODn` and `DEBOUNCE_CYCLES` values.
- **Sub-module `key_debounce`** contains the synchronizer, the FSM and the debounce counter. Its ports are `CLOCK_50`, `reset`, `KEY` and `key_pulse`.
- **Top level** contains the rate register, the period mux, `cnt` and `tick`.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `PERIOD0..3`=4, 6, 8, 10.
- **Reset, run_en=1, KEY=1:** `tick` pulses one cycle after edges 4, 8 and 12. `rate_sel`=0 and `key_pulse`=0 throughout.
- **Clean press (KEY←0 sampled at edge 1, held):** `key_pulse` is high only after edge 6. `rate_sel`=1 after edge 7. Next ticks are spaced 6 cycles, the first appearing 6 edges after the counter clear.
- **Bouncy press (KEY 0 for 2 cycles, 1 for 1, then 0 held):** exactly one `key_pulse`, timed from the last falling sample. Four clean press/release cycles wrap `rate_sel` through 1, 2, 3 and back to 0.
- **run_en=0 for 5 cycles at `cnt`=2:** no tick during that window. With `run_en`=1 again, the tick appears after 2 more edges (period 4).
- **Simultaneous events:** align `key_pulse` with the terminal count so that no tick occurs on that edge and `cnt` restarts. Separately, assert `reset` mid-debounce with the key held: outputs clear immediately, and one `key_pulse` follows 3+`DEBOUNCE_CYCLES`-1 edges after release.

Source files
------------

// File: rtl/blink_pkg.sv
// Shared constants for the LED blinker front end: debounce FSM encoding,
// rate index width and default timing values for a 50 MHz clock.
package blink_pkg;

    localparam int unsigned RATE_W = 2;

    // Debounce FSM state encoding
    localparam logic [1:0] ST_UP        = 2'd0;
    localparam logic [1:0] ST_DOWN_PEND = 2'd1;
    localparam logic [1:0] ST_DOWN      = 2'd2;
    localparam logic [1:0] ST_UP_PEND   = 2'd3;

    localparam int unsigned     DEF_DEBOUNCE_CYCLES = 250000;
    localparam longint unsigned DEF_PERIOD0         = 64'd5000;
    localparam longint unsigned DEF_PERIOD1         = 64'd500000;
    localparam longint unsigned DEF_PERIOD2         = 64'd5000000;
    localparam longint unsigned DEF_PERIOD3         = 64'd25000000;

    // Rate index steps 0..3 and wraps back to 0
    function automatic logic [RATE_W-1:0] next_rate(input logic [RATE_W-1:0] rate);
        return rate + 1'b1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronizes the raw active-low push button and debounces it; emits a
// one-cycle registered pulse per accepted press (never on release).
module key_debounce
    import blink_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic KEY,
    output logic key_pulse
);

    localparam int unsigned       DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            s1_q, s2_q;
    logic [1:0]      state_q, state_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d, db_cnt_inc;
    logic            key_pulse_q, key_pulse_d;

    // Two-flop synchronizer; resets to the released level
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= KEY;
            s2_q <= s1_q;
        end
    end

    // Debounce FSM next state; the counter saturates only via the state change
    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        key_pulse_d = 1'b0;
        db_cnt_inc  = db_cnt_q + 1'b1;
        case (state_q)
            ST_UP: begin
                if (!s2_q) begin
                    state_d  = ST_DOWN_PEND;
                    db_cnt_d = '0;
                end
            end
            ST_DOWN_PEND: begin
                if (s2_q) begin
                    state_d = ST_UP;
                end else begin
                    db_cnt_d = db_cnt_inc;
                    if (db_cnt_inc == DB_LAST) begin
                        state_d     = ST_DOWN;
                        key_pulse_d = 1'b1;
                    end
                end
            end
            ST_DOWN: begin
                if (s2_q) begin
                    state_d  = ST_UP_PEND;
                    db_cnt_d = '0;
                end
            end
            ST_UP_PEND: begin
                if (!s2_q) begin
                    state_d = ST_DOWN;
                end else begin
                    db_cnt_d = db_cnt_inc;
                    if (db_cnt_inc == DB_LAST) begin
                        state_d = ST_UP;
                    end
                end
            end
            default: state_d = ST_UP;
        endcase
    end

    // FSM, debounce counter and press pulse registers
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q     <= ST_UP;
            db_cnt_q    <= '0;
            key_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            key_pulse_q <= key_pulse_d;
        end
    end

    assign key_pulse = key_pulse_q;

endmodule

// File: rtl/blink_tick_gen.sv
// Blinker front end: debounced button steps through four rates, and a
// period counter emits a one-cycle tick at the selected period.
module blink_tick_gen
    import blink_pkg::*;
#(
    parameter int unsigned     DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter longint unsigned PERIOD0         = DEF_PERIOD0,
    parameter longint unsigned PERIOD1         = DEF_PERIOD1,
    parameter longint unsigned PERIOD2         = DEF_PERIOD2,
    parameter longint unsigned PERIOD3         = DEF_PERIOD3,
    parameter int unsigned     CNT_W           = 33
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       KEY,
    input  logic       run_en,
    output logic       tick,
    output logic [1:0] rate_sel,
    output logic       key_pulse
);

    logic [RATE_W-1:0] rate_q, rate_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, period_last;
    logic              tick_q, tick_d;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .KEY      (KEY),
        .key_pulse(key_pulse)
    );

    // Terminal count for the currently selected rate
    always_comb begin
        case (rate_q)
            2'd0:    period_last = CNT_W'(PERIOD0 - 64'd1);
            2'd1:    period_last = CNT_W'(PERIOD1 - 64'd1);
            2'd2:    period_last = CNT_W'(PERIOD2 - 64'd1);
            default: period_last = CNT_W'(PERIOD3 - 64'd1);
        endcase
    end

    // Rate step and period counter; a press outranks run_en and terminal count
    always_comb begin
        rate_d = rate_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (key_pulse) begin
            rate_d = next_rate(rate_q);
            cnt_d  = '0;
        end else if (!run_en) begin
            cnt_d = cnt_q;
        end else if (cnt_q == period_last) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Rate, counter and tick registers
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            rate_q <= '0;
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            rate_q <= rate_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick     = tick_q;
    assign rate_sel = rate_q;

endmodule

// File: tb/tb_blink_tick_gen.sv
// Self-checking bench: directed timing checks plus randomized key/run_en
// stimulus compared each cycle against a run-length reference model.
module tb_blink_tick_gen;

    localparam int unsigned DB = 4;
    localparam int unsigned P0 = 4;
    localparam int unsigned P1 = 6;
    localparam int unsigned P2 = 8;
    localparam int unsigned P3 = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_in;
    logic       run_en;
    logic       tick;
    logic [1:0] rate_sel;
    logic       key_pulse;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    // Reference model state
    logic        m_s1, m_s2, m_level, m_kp, m_tick;
    int unsigned m_run, m_rate, m_elapsed;

    always #5 clk = ~clk;

    blink_tick_gen #(
        .DEBOUNCE_CYCLES(DB),
        .PERIOD0        (64'(P0)),
        .PERIOD1        (64'(P1)),
        .PERIOD2        (64'(P2)),
        .PERIOD3        (64'(P3)),
        .CNT_W          (33)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .KEY      (key_in),
        .run_en   (run_en),
        .tick     (tick),
        .rate_sel (rate_sel),
        .key_pulse(key_pulse)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned period_of(input int unsigned r);
        case (r)
            0:       return P0;
            1:       return P1;
            2:       return P2;
            default: return P3;
        endcase
    endfunction

    task automatic reset_model();
        m_s1 = 1'b1; m_s2 = 1'b1; m_level = 1'b1; m_run = 0;
        m_kp = 1'b0; m_rate = 0; m_elapsed = 0; m_tick = 1'b0;
    endtask

    // One clock edge of the model: a press is accepted after DB consecutive
    // synchronized samples disagreeing with the debounced level.
    task automatic model_step();
        logic s2_old, kp_old;
        s2_old = m_s2;
        m_s2   = m_s1;
        m_s1   = key_in;
        kp_old = m_kp;
        m_kp   = 1'b0;
        if (s2_old == m_level) begin
            m_run = 0;
        end else begin
            m_run++;
            if (m_run == DB) begin
                m_level = s2_old;
                m_run   = 0;
                m_kp    = (s2_old == 1'b0);
            end
        end
        m_tick = 1'b0;
        if (kp_old) begin
            m_rate    = (m_rate + 1) % 4;
            m_elapsed = 0;
        end else if (run_en) begin
            m_elapsed++;
            if (m_elapsed == period_of(m_rate)) begin
                m_tick    = 1'b1;
                m_elapsed = 0;
            end
        end
    endtask

    task automatic compare_all(input string where);
        check_val({where, "_tick"}, 32'(tick), 32'(m_tick));
        check_val({where, "_rate"}, 32'(rate_sel), m_rate);
        check_val({where, "_kpulse"}, 32'(key_pulse), 32'(m_kp));
    endtask

    task automatic cycle(input logic k, input logic en);
        key_in = k;
        run_en = en;
        @(posedge clk);
        model_step();
        #1;
        compare_all("cyc");
    endtask

    task automatic do_reset(input logic k);
        key_in = k;
        rst    = 1'b1;
        #1;
        reset_model();
        compare_all("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int unsigned ticks;
    int unsigned pulses;
    int          first_edge;
    logic        lvl;
    int unsigned len;

    initial begin
        rst    = 1'b1;
        key_in = 1'b1;
        run_en = 1'b1;
        reset_model();

        // Idle after reset: ticks after edges 4, 8, 12 only
        do_reset(1'b1);
        ticks = 0;
        for (int i = 1; i <= 12; i++) begin
            cycle(1'b1, 1'b1);
            if (tick) begin
                ticks++;
                check_val("idle_tick_edge", 32'(i % 4), 0);
            end
        end
        check_val("idle_tick_count", ticks, 3);

        // Clean press held: pulse after edge 6 only, one pulse while held
        do_reset(1'b1);
        first_edge = -1;
        pulses     = 0;
        for (int i = 1; i <= 30; i++) begin
            cycle(1'b0, 1'b1);
            if (key_pulse) begin
                pulses++;
                if (first_edge < 0) first_edge = i;
            end
        end
        check_val("press_edge", 32'(first_edge), 6);
        check_val("held_pulses", pulses, 1);
        check_val("press_rate", 32'(rate_sel), 1);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1);

        // run_en low for 5 cycles at cnt=2, then tick 2 edges later
        do_reset(1'b1);
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        ticks = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0);
            if (tick) ticks++;
        end
        check_val("frozen_ticks", ticks, 0);
        cycle(1'b1, 1'b1);
        check_val("resume_edge1", 32'(tick), 0);
        cycle(1'b1, 1'b1);
        check_val("resume_edge2", 32'(tick), 1);

        // Reset mid-debounce with key held: pulse 3+DB-1 edges after release
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);
        do_reset(1'b0);
        first_edge = -1;
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b0, 1'b1);
            if (key_pulse && first_edge < 0) first_edge = i;
        end
        check_val("reset_press_edge", 32'(first_edge), 3 + DB - 1);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1);

        // Randomized bouncy key segments, mostly running, occasional reset
        for (int seg = 0; seg < 500; seg++) begin
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 8);
            if ($urandom_range(0, 3) == 0) len += 10;
            if ($urandom_range(0, 149) == 0) do_reset(lvl);
            for (int k = 0; k < int'(len); k++) begin
                cycle(lvl, $urandom_range(0, 3) != 0);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
